// File: rtl/sprite_anim_sequencer.sv
// Per-character animation controller: picks sprite frame and facing once per vsync rise.
// Optional feature macro ANIM_PAUSE_EN adds a `pause` input that freezes all animation state.
module sprite_anim_sequencer #(
  parameter int TICKS_PER_FRAME = 6,
  parameter int RUN_FRAMES      = 2
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       vsync,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       on_ground,
  input  logic       rising,
`ifdef ANIM_PAUSE_EN
  input  logic       pause,
`endif
  output logic [2:0] frame_sel,
  output logic       facing_left,
  output logic [1:0] anim_state,
  output logic       frame_strobe
);

  localparam int CW = $clog2(TICKS_PER_FRAME + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    JUMP = 2'd2,
    FALL = 2'd3
  } anim_e;

  anim_e           r_state;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_frame;
  logic            r_facing;
  logic            r_strobe;
  logic            r_vsyncD;

  anim_e           w_nextState;
  logic [CW-1:0]   w_nextCnt;
  logic [2:0]      w_nextFrame;
  logic            w_nextFacing;
  logic            w_tick;
  logic            w_horiz;

  // vsync_d keeps tracking vsync even while paused, so un-pausing mid-pulse cannot fake a rise.
`ifdef ANIM_PAUSE_EN
  assign w_tick = vsync & ~r_vsyncD & ~pause;
`else
  assign w_tick = vsync & ~r_vsyncD;
`endif

  assign w_horiz = key_left ^ key_right;

  always_comb begin
    w_nextState  = r_state;
    w_nextCnt    = r_cnt;
    w_nextFrame  = r_frame;
    w_nextFacing = r_facing;

    if (key_left & ~key_right)
      w_nextFacing = 1'b1;
    else if (key_right & ~key_left)
      w_nextFacing = 1'b0;

    if (~on_ground)
      w_nextState = rising ? JUMP : FALL;
    else
      w_nextState = w_horiz ? RUN : IDLE;

    if (w_nextState != r_state) begin
      w_nextCnt = '0;
      unique case (w_nextState)
        IDLE:    w_nextFrame = 3'd0;
        RUN:     w_nextFrame = 3'd1;
        JUMP:    w_nextFrame = 3'd4;
        default: w_nextFrame = 3'd5;
      endcase
    end else if (r_state == RUN) begin
      // Each run frame is shown for TICKS_PER_FRAME ticks before stepping; wraps back to frame 1.
      if (r_cnt == CW'(TICKS_PER_FRAME - 1)) begin
        w_nextCnt   = '0;
        w_nextFrame = (r_frame == 3'(RUN_FRAMES)) ? 3'd1 : r_frame + 3'd1;
      end else begin
        w_nextCnt = r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_frame  <= 3'd0;
      r_facing <= 1'b0;
      r_strobe <= 1'b0;
      r_vsyncD <= 1'b0;
    end else begin
      r_vsyncD <= vsync;
      if (w_tick) begin
        r_state  <= w_nextState;
        r_cnt    <= w_nextCnt;
        r_frame  <= w_nextFrame;
        r_facing <= w_nextFacing;
        r_strobe <= (w_nextFrame != r_frame) | (w_nextFacing != r_facing);
      end else begin
        r_strobe <= 1'b0;
      end
    end
  end

  assign frame_sel    = r_frame;
  assign facing_left  = r_facing;
  assign anim_state   = r_state;
  assign frame_strobe = r_strobe;

endmodule
